mem_stage: RTL

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (used as effective address or as writeback data), rs2 store data, and the load/store control.
- Runs a valid/ready transaction on the data-memory bus, aligns and extends load data, and presents registered writeback results to the writeback stage.
- Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_pkg.sv | 50 +++++
 rtl/mem_align.sv | 43 ++++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM state
// encoding, byte-lane widths and small size/alignment helpers.
package mem_pkg;

  localparam int MASK_W = 8;  // byte enables per doubleword
  localparam int OFF_W  = 3;  // byte offset within a doubleword

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Unshifted byte-enable pattern for an access of the given size code.
  function automatic logic [MASK_W-1:0] size_byte_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_byte_mask = 8'h01;
      2'b01:   size_byte_mask = 8'h03;
      2'b10:   size_byte_mask = 8'h0F;
      default: size_byte_mask = 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [OFF_W-1:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

  // Fold illegal funct3 encodings onto the doubleword access.
  function automatic logic [2:0] norm_f3(input logic [2:0] f3, input logic is_store);
    if (is_store)
      norm_f3 = f3[2] ? F3_D : f3;
    else
      norm_f3 = (f3 == 3'b111) ? F3_D : f3;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the memory stage: builds the store data/mask for a
// doubleword bus and extracts/extends load data from the returned doubleword.
// Purely combinational.
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        i_st_f3,
  input  logic [OFF_W-1:0]  i_st_off,
  input  logic [XLEN-1:0]   i_store_data,
  output logic [XLEN-1:0]   o_wdata,
  output logic [MASK_W-1:0] o_wmask,
  input  logic [2:0]        i_ld_f3,
  input  logic [OFF_W-1:0]  i_ld_off,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [XLEN-1:0] w_sh;

  // Store lanes: shift data and enables up to the byte offset; a mask that
  // crosses the doubleword simply loses its upper bits.
  always_comb begin
    o_wdata = i_store_data << {i_st_off, 3'b000};
    o_wmask = size_byte_mask(i_st_f3[1:0]) << i_st_off;
  end

  // Load lanes: bring the addressed bytes down to bit 0, then extend.
  always_comb begin
    w_sh = i_rdata >> {i_ld_off, 3'b000};
    case (i_ld_f3)
      F3_B:    o_ld_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      F3_H:    o_ld_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      F3_W:    o_ld_data = {{(XLEN-32){w_sh[31]}}, w_sh[31:0]};
      F3_BU:   o_ld_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      F3_HU:   o_ld_data = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      F3_WU:   o_ld_data = {{(XLEN-32){1'b0}}, w_sh[31:0]};
      default: o_ld_data = w_sh;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Non-memory instructions pass through with one
// cycle of latency; loads/stores run one valid/ready request on the data bus,
// wait for the response and retire with registered writeback outputs.
// Optional build macro: MEM_MISALIGN_CHECK_EN (adds misalign_exc and retires
// misaligned accesses without touching memory).
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [2:0]        mem_funct3,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              rd_wen,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [XLEN-1:0]   dmem_addr,
  output logic              dmem_wen,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [MASK_W-1:0] dmem_wmask,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_rd_data
`ifdef MEM_MISALIGN_CHECK_EN
  ,output logic             misalign_exc
`endif
);

  state_t            r_state;
  logic [XLEN-1:0]   r_addr;
  logic [2:0]        r_f3;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_rd_wen;
  logic              r_is_load;
  logic              r_req_valid;
  logic              r_wen;
  logic [XLEN-1:0]   r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic              r_out_valid;
  logic [REG_AW-1:0] r_out_rd_addr;
  logic              r_out_rd_wen;
  logic [XLEN-1:0]   r_out_rd_data;

  logic              w_is_mem;
  logic              w_is_store;
  logic [2:0]        w_f3;
  logic              w_wen_eff;
  logic [XLEN-1:0]   w_st_wdata;
  logic [MASK_W-1:0] w_st_wmask;
  logic [XLEN-1:0]   w_ld_data;

  // A load wins when both mem_rd and mem_wr are set.
  assign w_is_mem   = mem_rd | mem_wr;
  assign w_is_store = mem_wr & ~mem_rd;
  assign w_f3       = norm_f3(mem_funct3, w_is_store);
  assign w_wen_eff  = rd_wen && (rd_addr != '0);

  mem_align #(.XLEN(XLEN)) u_align (
    .i_st_f3      (w_f3),
    .i_st_off     (alu_result[OFF_W-1:0]),
    .i_store_data (store_data),
    .o_wdata      (w_st_wdata),
    .o_wmask      (w_st_wmask),
    .i_ld_f3      (r_f3),
    .i_ld_off     (r_addr[OFF_W-1:0]),
    .i_rdata      (dmem_rdata),
    .o_ld_data    (w_ld_data)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  logic w_misalign;
  logic r_misalign_exc;
  assign w_misalign   = (alu_result[OFF_W-1:0] & align_mask(w_f3[1:0])) != '0;
  assign misalign_exc = r_misalign_exc;
`endif

  // Control FSM plus the request and writeback registers it loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_f3          <= '0;
      r_rd_addr     <= '0;
      r_rd_wen      <= 1'b0;
      r_is_load     <= 1'b0;
      r_req_valid   <= 1'b0;
      r_wen         <= 1'b0;
      r_wdata       <= '0;
      r_wmask       <= '0;
      r_out_valid   <= 1'b0;
      r_out_rd_addr <= '0;
      r_out_rd_wen  <= 1'b0;
      r_out_rd_data <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign_exc <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
      r_misalign_exc <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_is_mem) begin
`ifdef MEM_MISALIGN_CHECK_EN
              if (w_misalign) begin
                r_out_valid    <= 1'b1;
                r_misalign_exc <= 1'b1;
                r_out_rd_addr  <= rd_addr;
                r_out_rd_wen   <= 1'b0;
                r_out_rd_data  <= '0;
              end else
`endif
              begin
                r_addr      <= alu_result;
                r_f3        <= w_f3;
                r_rd_addr   <= rd_addr;
                r_rd_wen    <= w_wen_eff & ~w_is_store;
                r_is_load   <= ~w_is_store;
                r_wen       <= w_is_store;
                r_wdata     <= w_is_store ? w_st_wdata : '0;
                r_wmask     <= w_is_store ? w_st_wmask : '0;
                r_req_valid <= 1'b1;
                r_state     <= REQ;
              end
            end else begin
              r_out_valid   <= 1'b1;
              r_out_rd_addr <= rd_addr;
              r_out_rd_wen  <= w_wen_eff;
              r_out_rd_data <= alu_result;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            r_out_valid   <= 1'b1;
            r_out_rd_addr <= r_rd_addr;
            r_out_rd_wen  <= r_rd_wen;
            r_out_rd_data <= r_is_load ? w_ld_data : '0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign dmem_req_valid = r_req_valid;
  assign dmem_addr      = {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign dmem_wen       = r_wen;
  assign dmem_wdata     = r_wdata;
  assign dmem_wmask     = r_wmask;
  assign out_valid      = r_out_valid;
  assign out_rd_addr    = r_out_rd_addr;
  assign out_rd_wen     = r_out_rd_wen;
  assign out_rd_data    = r_out_rd_data;

endmodule
